adder_sum_accumulator: RTL and testbench

- Downstream consumer of the registered adder result (sum, ADDER_WIDTH+1 bits).
- Accumulates a programmable window of valid sums into a wider accumulator.
- Presents the total to a sink through a valid/ready handshake.
- Used in arithmetic benchmark harnesses to observe the adder output over many cycles without exposing every sum at the pins.

---
 rtl/adder_sum_accumulator.sv | 121 ++++++++++++
 tb/tb_adder_sum_accumulator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
// Sums a programmable window of valid adder results into a wider accumulator.
// The total is then offered to a sink through a valid/ready handshake.
// A sticky flag records any carry lost out of the accumulator during the window.
module adder_sum_accumulator #(
  parameter int ADDER_WIDTH = 51,
  parameter int ACC_WIDTH   = 64,  // must be >= ADDER_WIDTH+1
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] window_len,
  input  logic                   sum_valid,
  input  logic [ADDER_WIDTH:0]   sum,
  output logic                   busy,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic [COUNT_WIDTH-1:0] acc_count,
  output logic                   acc_overflow,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  // One extra bit above the accumulator catches the carry-out of each add.
  logic [ACC_WIDTH:0]     sum_full;
  logic [COUNT_WIDTH-1:0] count_inc;

  assign sum_full  = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(sum)};
  assign count_inc = count_q + COUNT_WIDTH'(1);

  // State and datapath registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath update for the IDLE / ACCUM / HOLD sequence.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = window_len;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          // An empty window skips accumulation; its result is raised one
          // cycle later from HOLD, matching the latency of a one-sample window.
          state_d = (window_len != '0) ? ST_ACCUM : ST_HOLD;
        end
      end

      ST_ACCUM: begin
        if (sum_valid) begin
          acc_d   = sum_full[ACC_WIDTH-1:0];
          ovf_d   = ovf_q | sum_full[ACC_WIDTH];
          count_d = count_inc;
          // Counter stops at len_q, so it never wraps even for the maximum window.
          if (count_inc == len_q) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (!valid_q) begin
          // Entered directly from IDLE with an empty window.
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign acc_out      = acc_q;
  assign acc_count    = count_q;
  assign acc_overflow = ovf_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb_adder_sum_accumulator
// Two instances share all inputs: the default 64-bit accumulator and a 52-bit
// one that can overflow. A window-level model keeps the exact (unbounded) total
// of accepted sums; each instance's expectations are that total reduced to its width.
module tb_adder_sum_accumulator;

  localparam int AW = 51;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] window_len = '0;
  logic          sum_valid = 1'b0;
  logic [AW:0]   sum = '0;
  logic          out_ready = 1'b0;

  logic          busy_a, busy_b;
  logic [63:0]   acc_a;
  logic [51:0]   acc_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          ovf_a, ovf_b;
  logic          vld_a, vld_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.ADDER_WIDTH(AW), .ACC_WIDTH(64), .COUNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .window_len(window_len),
    .sum_valid(sum_valid), .sum(sum), .busy(busy_a), .acc_out(acc_a),
    .acc_count(cnt_a), .acc_overflow(ovf_a), .out_valid(vld_a), .out_ready(out_ready)
  );

  adder_sum_accumulator #(.ADDER_WIDTH(AW), .ACC_WIDTH(52), .COUNT_WIDTH(CW)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .window_len(window_len),
    .sum_valid(sum_valid), .sum(sum), .busy(busy_b), .acc_out(acc_b),
    .acc_count(cnt_b), .acc_overflow(ovf_b), .out_valid(vld_b), .out_ready(out_ready)
  );

  // ---------------- window-level model ----------------
  logic          m_busy = 1'b0;   // a window is open (started, not yet handed off)
  logic          m_valid = 1'b0;  // result is on offer
  logic [127:0]  m_total = '0;    // exact sum of the window's accepted samples
  int            m_count = 0;
  int            m_need = 0;      // samples still missing from the window

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_total <= '0;
      m_count <= 0;
      m_need  <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy  <= 1'b1;
        m_total <= '0;
        m_count <= 0;
        m_need  <= int'(window_len);
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_need == 0) begin
      m_valid <= 1'b1;                       // empty window result
    end else if (sum_valid) begin
      m_total <= m_total + 128'(sum);
      m_count <= m_count + 1;
      m_need  <= m_need - 1;
      if (m_need == 1) m_valid <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances against the model (sampled on the falling edge).
  always @(negedge clk) begin
    chk("busy_a",  128'(busy_a), 128'(m_busy));
    chk("valid_a", 128'(vld_a),  128'(m_valid));
    chk("acc_a",   128'(acc_a),  128'(m_total[63:0]));
    chk("cnt_a",   128'(cnt_a),  128'(m_count));
    chk("ovf_a",   128'(ovf_a),  128'(|m_total[127:64]));
    chk("busy_b",  128'(busy_b), 128'(m_busy));
    chk("valid_b", 128'(vld_b),  128'(m_valid));
    chk("acc_b",   128'(acc_b),  128'(m_total[51:0]));
    chk("cnt_b",   128'(cnt_b),  128'(m_count));
    chk("ovf_b",   128'(ovf_b),  128'(|m_total[127:52]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [AW:0] v);
    sum_valid = 1'b1;
    sum = v;
    tick();
    sum_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW:0] big;

    // Reset, then idle for 10 cycles.
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("idle busy", 128'(busy_a), 128'd0);
    chk("idle acc",  128'(acc_a),  128'd0);
    #2 reset_n = 1'b0;
    #1 chk("idle rst valid", 128'(vld_a), 128'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Window of 3: 5, 7, 2^51 back to back.
    out_ready = 1'b1;
    start = 1'b1; window_len = 8'd3;
    tick();
    start = 1'b0;
    feed(52'd5);
    sum_valid = 1'b1; sum = 52'd7; tick();
    chk("w3 not yet valid", 128'(vld_a), 128'd0);
    big = 52'd1 << 51;
    feed(big);
    chk("w3 valid", 128'(vld_a), 128'd1);
    chk("w3 acc",   128'(acc_a), 128'h0008_0000_0000_000C);
    chk("w3 cnt",   128'(cnt_a), 128'd3);
    chk("w3 ovf",   128'(ovf_a), 128'd0);
    tick();
    chk("w3 idle busy", 128'(busy_a), 128'd0);
    chk("w3 idle acc",  128'(acc_a),  128'h0008_0000_0000_000C);

    // Gapped input with backpressure.
    out_ready = 1'b0;
    start = 1'b1; window_len = 8'd2;
    tick();
    start = 1'b0;
    feed(52'd100);
    repeat (4) tick();
    feed(52'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 128'(vld_a), 128'd1);
      chk("bp acc",   128'(acc_a), 128'd101);
      if (i == 2) feed(52'd999); else tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp released", 128'(vld_a), 128'd0);
    chk("bp acc kept", 128'(acc_a), 128'd101);

    // Overflow on the 52-bit instance.
    start = 1'b1; window_len = 8'd2;
    tick();
    start = 1'b0;
    feed(52'hF_FFFF_FFFF_FFFF);
    feed(52'd2);
    chk("ovf acc_b", 128'(acc_b), 128'd1);
    chk("ovf flag_b", 128'(ovf_b), 128'd1);
    chk("ovf acc_a", 128'(acc_a), 128'h0010_0000_0000_0001);
    tick();
    start = 1'b1; window_len = 8'd1;
    tick();
    start = 1'b0;
    feed(52'd4);
    chk("ovf clr flag_b", 128'(ovf_b), 128'd0);
    chk("ovf clr acc_b",  128'(acc_b), 128'd4);
    tick();

    // Empty window.
    start = 1'b1; window_len = 8'd0;
    tick();
    start = 1'b0;
    chk("empty early valid", 128'(vld_a),  128'd0);
    chk("empty busy",        128'(busy_a), 128'd1);
    tick();
    chk("empty valid", 128'(vld_a), 128'd1);
    chk("empty acc",   128'(acc_a), 128'd0);
    chk("empty cnt",   128'(cnt_a), 128'd0);
    tick();

    // Start pulses while busy are ignored.
    out_ready = 1'b0;
    start = 1'b1; window_len = 8'd3;
    tick();
    start = 1'b0;
    feed(52'd10);
    start = 1'b1; window_len = 8'd1;
    feed(52'd20);
    start = 1'b0;
    feed(52'd30);
    chk("busy start acc", 128'(acc_a), 128'd60);
    chk("busy start cnt", 128'(cnt_a), 128'd3);
    start = 1'b1; out_ready = 1'b1;   // start coincident with handoff edge
    tick();
    start = 1'b0;
    chk("handoff start busy", 128'(busy_a), 128'd0);
    chk("handoff start acc",  128'(acc_a),  128'd60);

    // Reset mid-window.
    start = 1'b1; window_len = 8'd4;
    tick();
    start = 1'b0;
    feed(52'd3);
    feed(52'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("rst busy",  128'(busy_a), 128'd0);
    chk("rst valid", 128'(vld_a),  128'd0);
    chk("rst acc",   128'(acc_a),  128'd0);
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1; window_len = 8'd1;
    tick();
    start = 1'b0;
    feed(52'd9);
    chk("post rst acc", 128'(acc_a), 128'd9);
    tick();

    // Maximum window of 255 ones.
    start = 1'b1; window_len = 8'd255;
    tick();
    start = 1'b0;
    for (int i = 0; i < 255; i++) feed(52'd1);
    chk("max acc", 128'(acc_a), 128'd255);
    chk("max cnt", 128'(cnt_a), 128'd255);
    tick();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
